// File: rtl/seg7_wr_if.sv
// Register-write port for the 7-segment scan controller.
// Handshake: wr_en is a single-cycle strobe qualifying wr_addr/wr_data/wr_dp/
// wr_blank on the same rising edge; there is no ready, every strobe is accepted.
interface seg7_wr_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          wr_blank;

  modport master (output wr_en, wr_addr, wr_data, wr_dp, wr_blank);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp, wr_blank);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner: per-digit nibble/dp/blank
// store, programmable dwell, anti-ghosting blank window at the start of each
// slot, hex decode and optional leading-zero suppression. All outputs are
// registered and reflect the pre-edge scan state.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int AW         = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_wr_if.slave              wr,
  input  logic                  lz_en,
  input  logic                  scan_en,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [AW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int              CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   BLK_END = CW'(BLANK_CYC);
  localparam logic [AW-1:0]   IDX_MAX = AW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [AW-1:0]         idx;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_r;
  logic [NUM_DIGITS-1:0] blank_r;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_supp;
  logic [NUM_DIGITS-1:0] sel_n;
  logic [NUM_DIGITS-1:0] supp;
  logic                  run;

  // Active-low segment pattern (g..a) for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h58;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Digit store: addresses beyond the last digit match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) nib[i] <= '0;
      dp_r    <= '0;
      blank_r <= '1;
    end else if (wr.wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr.wr_addr == AW'(i)) begin
          nib[i]     <= wr.wr_data;
          dp_r[i]    <= wr.wr_dp;
          blank_r[i] <= wr.wr_blank;
        end
      end
    end
  end

  // Dwell prescaler and digit index; both freeze while scan_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (scan_en) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Select the entry and one-cold enable for the digit in its slot.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_supp  = 1'b0;
    sel_n     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == AW'(i)) begin
        cur_nib   = nib[i];
        cur_dp    = dp_r[i];
        cur_blank = blank_r[i];
        cur_supp  = supp[i];
        sel_n[i]  = 1'b0;
      end
    end
  end

  // Leading-zero suppression: walk down from the top digit while every digit
  // seen so far is zero-or-blank with no decimal point; digit 0 always shows.
  always_comb begin
    supp = '0;
    run  = lz_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run     = run & ((nib[i] == 4'h0) | blank_r[i]) & ~dp_r[i];
      supp[i] = run;
    end
  end

  // Registered outputs: blank window or scan hold turns everything off; a
  // blank/suppressed digit keeps its enable but lights no segments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_out    <= 8'hFF;
      dig_sel    <= '1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      digit_idx  <= idx;
      frame_tick <= (idx == '0) && (digit_idx == IDX_MAX);
      if (!scan_en || (cnt < BLK_END)) begin
        seg_out <= 8'hFF;
        dig_sel <= '1;
      end else begin
        dig_sel <= sel_n;
        seg_out <= (cur_blank || cur_supp) ? 8'hFF : {~cur_dp, seg_decode(cur_nib)};
      end
    end
  end

endmodule
